// File: rtl/stopwatch_bcd_if.sv
// Stopwatch control/display bundle: tick and button levels in, BCD digits and status flags out.
// Master drives stimulus and reads the display; slave is the stopwatch core.
interface stopwatch_bcd_if;
  logic       tick;
  logic       btn_start;
  logic       btn_lap;
  logic       btn_clear;
  logic [3:0] tenths;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic       running;
  logic       lap_active;
  logic       rollover;

  modport master (
    output tick, btn_start, btn_lap, btn_clear,
    input  tenths, sec_ones, sec_tens, min_ones, running, lap_active, rollover
  );

  modport slave (
    input  tick, btn_start, btn_lap, btn_clear,
    output tenths, sec_ones, sec_tens, min_ones, running, lap_active, rollover
  );
endinterface

// File: rtl/stopwatch_bcd.sv
// BCD M:SS.t stopwatch with start/stop, lap freeze and clear; digits update on the tick edge.
// Always accepts tick and button edges (no backpressure); rollover is a registered one-cycle pulse.
module stopwatch_bcd #(
  parameter bit SAT = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  stopwatch_bcd_if.slave sw
);

  typedef struct packed {
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] tenths;
  } bcd_time_t;

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  localparam bcd_time_t TIME_MAX = bcd_time_t'(16'h9599);

  state_t    state_q, state_d;
  bcd_time_t live_q, live_d;
  bcd_time_t lap_q, lap_d;
  bcd_time_t disp;
  logic      lap_act_q, lap_act_d;
  logic      roll_q, roll_d;
  logic      start_hist, lap_hist, clear_hist;
  logic      start_e, lap_e, clear_e;
  logic      count_en, at_max;

  function automatic bcd_time_t bcd_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.tenths < 4'd9) begin
      r.tenths = t.tenths + 4'd1;
    end else begin
      r.tenths = 4'd0;
      if (t.sec_ones < 4'd9) begin
        r.sec_ones = t.sec_ones + 4'd1;
      end else begin
        r.sec_ones = 4'd0;
        if (t.sec_tens < 4'd5) begin
          r.sec_tens = t.sec_tens + 4'd1;
        end else begin
          r.sec_tens = 4'd0;
          r.min_ones = (t.min_ones < 4'd9) ? t.min_ones + 4'd1 : 4'd0;
        end
      end
    end
    return r;
  endfunction

  // History tracks the level even in reset, so a button held through reset yields no edge.
  always_ff @(posedge clk) begin
    start_hist <= sw.btn_start;
    lap_hist   <= sw.btn_lap;
    clear_hist <= sw.btn_clear;
  end

  assign start_e = sw.btn_start & ~start_hist;
  assign lap_e   = sw.btn_lap & ~lap_hist;
  assign clear_e = sw.btn_clear & ~clear_hist;

  assign count_en = (state_q == RUN) && sw.tick;
  assign at_max   = (live_q == TIME_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      live_q    <= '0;
      lap_q     <= '0;
      lap_act_q <= 1'b0;
      roll_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      live_q    <= live_d;
      lap_q     <= lap_d;
      lap_act_q <= lap_act_d;
      roll_q    <= roll_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    live_d    = live_q;
    lap_d     = lap_q;
    lap_act_d = lap_act_q;
    roll_d    = 1'b0;

    if (count_en) begin
      if (at_max) begin
        roll_d = 1'b1;
        live_d = SAT ? TIME_MAX : '0;
      end else begin
        live_d = bcd_inc(live_q);
      end
    end

    unique case (state_q)
      IDLE:    if (start_e) state_d = RUN;
      RUN:     if (start_e || (SAT && count_en && at_max)) state_d = STOP;
      STOP:    if (start_e) state_d = RUN;
      default: state_d = IDLE;
    endcase

    // Lap captures the pre-increment registered count.
    if (lap_e) begin
      if (lap_act_q) begin
        lap_act_d = 1'b0;
      end else if (state_q == RUN) begin
        lap_d     = live_q;
        lap_act_d = 1'b1;
      end
    end

    if (clear_e) begin
      state_d   = IDLE;
      live_d    = '0;
      lap_act_d = 1'b0;
      roll_d    = 1'b0;
    end
  end

  assign disp          = lap_act_q ? lap_q : live_q;
  assign sw.tenths     = disp.tenths;
  assign sw.sec_ones   = disp.sec_ones;
  assign sw.sec_tens   = disp.sec_tens;
  assign sw.min_ones   = disp.min_ones;
  assign sw.running    = (state_q == RUN);
  assign sw.lap_active = lap_act_q;
  assign sw.rollover   = roll_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd: one wrapping (SAT=0) and one saturating (SAT=1) instance
// share stimulus; outputs are sampled 1 ns after each rising edge.
module tb_stopwatch_bcd;
  logic clk;
  logic rst_n;
  int   checks;
  int   passed;

  stopwatch_bcd_if sw0 ();
  stopwatch_bcd_if sw1 ();

  stopwatch_bcd #(.SAT(1'b0)) u_wrap (.clk(clk), .rst_n(rst_n), .sw(sw0));
  stopwatch_bcd #(.SAT(1'b1)) u_sat  (.clk(clk), .rst_n(rst_n), .sw(sw1));

  assign sw1.tick      = sw0.tick;
  assign sw1.btn_start = sw0.btn_start;
  assign sw1.btn_lap   = sw0.btn_lap;
  assign sw1.btn_clear = sw0.btn_clear;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] disp0();
    return {sw0.min_ones, sw0.sec_tens, sw0.sec_ones, sw0.tenths};
  endfunction

  function automatic logic [15:0] disp1();
    return {sw1.min_ones, sw1.sec_tens, sw1.sec_ones, sw1.tenths};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      sw0.tick = 1'b1;
      cyc();
    end
    sw0.tick = 1'b0;
  endtask

  task automatic press_start();
    sw0.btn_start = 1'b1; cyc();
    sw0.btn_start = 1'b0; cyc();
  endtask

  task automatic press_lap();
    sw0.btn_lap = 1'b1; cyc();
    sw0.btn_lap = 1'b0; cyc();
  endtask

  task automatic press_clear();
    sw0.btn_clear = 1'b1; cyc();
    sw0.btn_clear = 1'b0; cyc();
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst_n = 1'b0;
    sw0.tick = 1'b0;
    sw0.btn_start = 1'b0;
    sw0.btn_lap = 1'b0;
    sw0.btn_clear = 1'b0;
    cyc(); cyc();

    // Reset state
    chk("rst_digits", disp0(), 16'h0000);
    chk("rst_flags", {13'd0, sw0.running, sw0.lap_active, sw0.rollover}, 16'h0000);
    chk("rst_digits_sat", disp1(), 16'h0000);
    rst_n = 1'b1;
    cyc();

    // Start, 25 ticks, stop, 10 ignored ticks
    press_start();
    chk("start_running", {15'd0, sw0.running}, 16'h0001);
    ticks(25);
    chk("count_2_5", disp0(), 16'h0025);
    press_start();
    chk("stop_running", {15'd0, sw0.running}, 16'h0000);
    ticks(10);
    chk("stopped_hold", disp0(), 16'h0025);

    // Carry chain and rollover
    press_clear();
    chk("clear_digits", disp0(), 16'h0000);
    press_start();
    ticks(600);
    chk("count_1_00_0", disp0(), 16'h1000);
    ticks(5399);
    chk("count_9_59_9", disp0(), 16'h9599);
    chk("rollover_idle", {15'd0, sw0.rollover}, 16'h0000);
    sw0.tick = 1'b1; cyc(); sw0.tick = 1'b0;
    chk("wrap_digits", disp0(), 16'h0000);
    chk("wrap_rollover", {15'd0, sw0.rollover}, 16'h0001);
    chk("wrap_running", {15'd0, sw0.running}, 16'h0001);
    chk("sat_digits", disp1(), 16'h9599);
    chk("sat_rollover", {15'd0, sw1.rollover}, 16'h0001);
    chk("sat_running", {15'd0, sw1.running}, 16'h0000);
    cyc();
    chk("wrap_rollover_1cyc", {15'd0, sw0.rollover}, 16'h0000);
    chk("sat_rollover_1cyc", {15'd0, sw1.rollover}, 16'h0000);

    // Lap freeze and release
    press_clear();
    press_start();
    ticks(13);
    sw0.btn_lap = 1'b1; cyc(); sw0.btn_lap = 1'b0;
    chk("lap_active_on", {15'd0, sw0.lap_active}, 16'h0001);
    chk("lap_capture", disp0(), 16'h0013);
    ticks(7);
    chk("lap_frozen", disp0(), 16'h0013);
    press_lap();
    chk("lap_release", disp0(), 16'h0020);
    chk("lap_active_off", {15'd0, sw0.lap_active}, 16'h0000);
    press_start();
    press_lap();
    chk("lap_in_stop_ignored", {15'd0, sw0.lap_active}, 16'h0000);

    // Simultaneous events
    sw0.tick = 1'b1; sw0.btn_start = 1'b1; cyc();
    sw0.tick = 1'b0; sw0.btn_start = 1'b0;
    chk("tick_start_running", {15'd0, sw0.running}, 16'h0001);
    chk("tick_start_not_counted", disp0(), 16'h0020);
    cyc();
    sw0.tick = 1'b1; sw0.btn_start = 1'b1; cyc();
    sw0.tick = 1'b0; sw0.btn_start = 1'b0;
    chk("tick_stop_running", {15'd0, sw0.running}, 16'h0000);
    chk("tick_stop_counted", disp0(), 16'h0021);
    cyc();
    press_start();
    sw0.tick = 1'b1; sw0.btn_clear = 1'b1; cyc();
    sw0.tick = 1'b0; sw0.btn_clear = 1'b0;
    chk("tick_clear_digits", disp0(), 16'h0000);
    chk("tick_clear_idle", {15'd0, sw0.running}, 16'h0000);
    cyc();
    sw0.btn_start = 1'b1; sw0.btn_clear = 1'b1; cyc();
    sw0.btn_start = 1'b0; sw0.btn_clear = 1'b0;
    chk("start_clear_idle", {15'd0, sw0.running}, 16'h0000);
    cyc();
    ticks(3);
    chk("idle_no_count", disp0(), 16'h0000);

    // Held start: one transition, first tick uncounted, 999 counted = 1:39.9
    sw0.btn_start = 1'b1;
    ticks(1000);
    chk("held_start_running", {15'd0, sw0.running}, 16'h0001);
    chk("held_start_count", disp0(), 16'h1399);

    // Held through reset release: no action
    rst_n = 1'b0; cyc();
    chk("held_rst_running", {15'd0, sw0.running}, 16'h0000);
    rst_n = 1'b1; cyc(); cyc(); cyc();
    chk("held_rst_no_start", {15'd0, sw0.running}, 16'h0000);
    sw0.btn_start = 1'b0; cyc();

    // Mid-operation reset with lap active
    press_start();
    ticks(42);
    press_lap();
    chk("pre_rst_lap", {15'd0, sw0.lap_active}, 16'h0001);
    chk("pre_rst_digits", disp0(), 16'h0042);
    rst_n = 1'b0; sw0.tick = 1'b1; cyc();
    rst_n = 1'b1; sw0.tick = 1'b0;
    chk("mid_rst_digits", disp0(), 16'h0000);
    chk("mid_rst_flags", {13'd0, sw0.running, sw0.lap_active, sw0.rollover}, 16'h0000);
    ticks(3);
    chk("mid_rst_idle", disp0(), 16'h0000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/stopwatch_bcd.md
# stopwatch_bcd

- Consumes the 0.1 s `tick` pulse from the divider stage and keeps a start/stop stopwatch time of M:SS.t as four BCD digits, with lap freeze and clear.
- Downstream, a display driver reads the four BCD digits, plus the running and lap flags.
- All logic is on one 100 MHz clock. Button inputs are already synchronized and debounced levels.

## Interface
Parameters:
- `SAT`, default 0: 0 = wrap from 9:59.9 to 0:00.0 and keep running; 1 = hold at 9:59.9 and stop.

Ports:
- `clk`  in  1  100 MHz system clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `tick`  in  1  one-cycle pulse every 0.1 s from the divider.
- `btn_start`  in  1  start/stop toggle level; acts on its rising edge.
- `btn_lap`  in  1  lap freeze/release level; acts on its rising edge.
- `btn_clear`  in  1  clear level; acts on its rising edge.
- `tenths`  out  4  displayed tenths digit, BCD 0–9.
- `sec_ones`  out  4  displayed seconds units, BCD 0–9.
- `sec_tens`  out  4  displayed seconds tens, BCD 0–5.
- `min_ones`  out  4  displayed minutes, BCD 0–9.
- `running`  out  1  1 while in RUN.
- `lap_active`  out  1  1 while the display shows the frozen lap value.
- `rollover`  out  1  one-cycle pulse when the count passes 9:59.9.

## Operation
- **Edge detect:** each button has a history register. Edge = `btn & ~btn_q`, using the current input against the history register.
  - During reset, each history register loads the current button level, so a button held through reset does not produce an edge.
- **State machine** (reset state IDLE):
  - IDLE: live count is 0:00.0. Start edge → RUN.
  - RUN: start edge → STOP.
  - STOP: start edge → RUN.
  - In any state, a clear edge → IDLE, live count 0, lap_active 0.
- **Priority:** clear over start, and clear over tick.
- **Counting:** the live count increments by 0.1 s on a clock edge where `tick`=1 and the registered state is RUN.
  - The digit chain carries tenths 9→0, sec_ones 9→0, sec_tens 5→0, min_ones 9→0.
  - Each digit is a 4-bit counter; a digit never holds a value outside its range.
- **Rollover:** a tick in RUN at 9:59.9 pulses `rollover` for one cycle.
  - SAT=0: count goes to 0:00.0 and the state stays RUN.
  - SAT=1: count holds 9:59.9 and the state goes to STOP.
- **Lap:**
  - Lap edge in RUN with lap_active=0: lap registers capture the registered live count from before that edge's increment; lap_active becomes 1.
  - Lap edge with lap_active=1, in any state: lap_active becomes 0.
  - Lap edge with lap_active=0 in IDLE or STOP: ignored.
  - The live count keeps running while lap_active=1.
- **Display mux:** digit outputs equal the lap registers when lap_active=1, otherwise the live count. The mux is a 2:1 over registers with no added latency.

## Timing
- **Reset values:** all digit outputs 0, `running`=0, `lap_active`=0, `rollover`=0, state IDLE, lap registers 0.
- **Button latency:** one button edge takes effect on the first clock edge where the input is 1 and its history is 0. `running` is 1 from that edge onward.
- **Tick on the same edge as a start edge** from IDLE or STOP: the tick is not counted, because the registered state was not RUN.
- **Tick on the same edge as a stop edge:** the tick is counted.
- **Tick on the same edge as clear:** count becomes 0:00.0.
- **Start and clear on the same edge:** the result is IDLE.
- **Count latency:** the digits update on the tick edge itself. `rollover` is high in the cycle after the wrapping tick edge, for exactly one cycle.
- **Mid-operation reset** (`rst_n`=0 at any clock edge): everything returns to reset values on that edge, regardless of `tick` or buttons.
- **Held button:** one press produces exactly one action however long the level is held.

## Test plan
- Reset, start pulse, then 25 ticks → digits 0:02.5 and `running`=1. Stop, then 10 more ticks → still 0:02.5 and `running`=0.
- Start, then 600 ticks → 1:00.0 (carry chain check). Preload to 9:59.9 via 5999 ticks, then 1 more tick:
  - SAT=0 → 0:00.0, one-cycle `rollover`, `running`=1.
  - SAT=1 → holds 9:59.9, `rollover` pulse, `running`=0.
- RUN at 0:01.3, lap edge, then 7 ticks → outputs show 0:01.3. Second lap edge → outputs show 0:02.0 and `lap_active`=0.
- Simultaneous events:
  - tick with stop edge → counted.
  - tick with start edge from STOP → not counted.
  - tick with clear → 0:00.0 and IDLE.
  - start with clear → IDLE.
- `btn_start` held high for 1000 cycles with ticks → a single transition to RUN. Button held high through reset release → no action.
- Assert `rst_n`=0 for one cycle in RUN at 0:04.2 with lap_active=1 → all outputs 0 on the next edge, state IDLE.
